muldiv_controller: RTL

- Sequences the CPU's iterative multiplier and divider and owns the architectural HI/LO registers.
- Decodes MULT/DIV/MTHI/MTLO/MFHI/MFLO from the execute stage and issues one-cycle start pulses to the selected unit.
- Waits for the unit's done pulse, with a cycle-count timeout, then commits the result to HI/LO.
- Raises a pipeline stall while a HI/LO-dependent instruction must wait.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_controller_hilo_regs.sv | 47 ++++
 rtl/muldiv_controller.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the HI/LO multiply/divide sequencer.
//   muldiv_op_t    : execute-stage operation encoding (3 bits)
//   muldiv_state_t : sequencer FSM state encoding (2 bits)
//   is_hilo_read   : true for the operations that read HI or LO
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_MULT = 3'd1,
    OP_DIV  = 3'd2,
    OP_MTHI = 3'd3,
    OP_MTLO = 3'd4,
    OP_MFHI = 3'd5,
    OP_MFLO = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MULT_RUN = 2'd1,
    S_DIV_RUN  = 2'd2
  } muldiv_state_t;

  localparam int MULDIV_TIMEOUT_DEFAULT = 40;
  localparam int MULDIV_W_DEFAULT       = 32;

  function automatic logic is_hilo_read(input muldiv_op_t o);
    return (o == OP_MFHI) || (o == OP_MFLO);
  endfunction

endpackage

// File: rtl/muldiv_controller_hilo_regs.sv
// Architectural HI/LO register pair.
//   clock, reset       : rising-edge clock, asynchronous active-low reset
//   we_hi, we_lo       : independent write enables
//   hi_d, lo_d         : write data
//   hi, lo             : registered register contents
module hilo_regs #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         we_hi,
  input  logic         we_lo,
  input  logic [W-1:0] hi_d,
  input  logic [W-1:0] lo_d,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  logic [W-1:0] hi_r;
  logic [W-1:0] lo_r;

  // HI register: loaded on write enable, cleared by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_r <= {W{1'b0}};
    end else if (we_hi) begin
      hi_r <= hi_d;
    end else begin
      hi_r <= hi_r;
    end
  end

  // LO register: loaded on write enable, cleared by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lo_r <= {W{1'b0}};
    end else if (we_lo) begin
      lo_r <= lo_d;
    end else begin
      lo_r <= lo_r;
    end
  end

  assign hi = hi_r;
  assign lo = lo_r;

endmodule

// File: rtl/muldiv_controller.sv
// Sequencer for the iterative multiplier/divider; owns HI/LO.
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   op_valid/op         : execute-stage operation (muldiv_op_t)
//   rs_val/rt_val       : operands (rs_val also feeds MTHI/MTLO)
//   stall               : hold execute while a HI/LO user must wait
//   result/result_valid : MFHI/MFLO read data, same cycle
//   mult_start/div_start: one-cycle start pulses, op_a/op_b held for the run
//   mult_done/hi/lo     : multiplier completion and product
//   div_done/rem/quo    : divider completion and result
//   hi, lo              : architectural HI/LO
//   busy                : a run is in progress
//   div_zero_exc        : one-cycle pulse after a DIV by zero
//   timeout_err         : sticky, set when a run is abandoned
module muldiv_controller
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT = MULDIV_TIMEOUT_DEFAULT,
  parameter int W       = MULDIV_W_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         op_valid,
  input  logic [2:0]   op,
  input  logic [W-1:0] rs_val,
  input  logic [W-1:0] rt_val,
  output logic         stall,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         mult_start,
  output logic         div_start,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  input  logic         mult_done,
  input  logic [W-1:0] mult_hi,
  input  logic [W-1:0] mult_lo,
  input  logic         div_done,
  input  logic [W-1:0] div_rem,
  input  logic [W-1:0] div_quo,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         busy,
  output logic         div_zero_exc,
  output logic         timeout_err
);

  // Wide enough to hold TIMEOUT, so the final increment of a run never wraps.
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  muldiv_op_t    op_s;
  muldiv_state_t state_r;
  muldiv_state_t state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [W-1:0]  op_a_r;
  logic [W-1:0]  op_b_r;
  logic          mult_start_r;
  logic          div_start_r;
  logic          div_zero_exc_r;
  logic          timeout_err_r;

  logic          idle_req_s;
  logic          rt_zero_s;
  logic          issue_mult_s;
  logic          issue_div_s;
  logic          div_zero_s;
  logic          active_done_s;
  logic          timeout_fire_s;
  logic          we_hi_s;
  logic          we_lo_s;
  logic [W-1:0]  hi_d_s;
  logic [W-1:0]  lo_d_s;
  logic [W-1:0]  hi_q_s;
  logic [W-1:0]  lo_q_s;

  assign op_s         = muldiv_op_t'(op);
  assign idle_req_s   = op_valid && (state_r == S_IDLE);
  assign rt_zero_s    = (rt_val == {W{1'b0}});
  assign issue_mult_s = idle_req_s && (op_s == OP_MULT);
  assign issue_div_s  = idle_req_s && (op_s == OP_DIV) && !rt_zero_s;
  assign div_zero_s   = idle_req_s && (op_s == OP_DIV) && rt_zero_s;

  // Completion from the unit that owns the current run; the other unit's done is ignored
  always_comb begin
    active_done_s = 1'b0;
    case (state_r)
      S_MULT_RUN: active_done_s = mult_done;
      S_DIV_RUN:  active_done_s = div_done;
      default:    active_done_s = 1'b0;
    endcase
  end

  // A done in the last allowed cycle takes priority over the timeout
  assign timeout_fire_s = (state_r != S_IDLE) && !active_done_s && (cnt_r == CNT_LAST);

  // Next state and HI/LO write control
  always_comb begin
    state_nxt_s = state_r;
    we_hi_s     = 1'b0;
    we_lo_s     = 1'b0;
    hi_d_s      = rs_val;
    lo_d_s      = rs_val;
    case (state_r)
      S_IDLE: begin
        if (op_valid) begin
          case (op_s)
            OP_MULT: state_nxt_s = S_MULT_RUN;
            OP_DIV: begin
              if (!rt_zero_s) begin
                state_nxt_s = S_DIV_RUN;
              end else begin
                state_nxt_s = S_IDLE;
              end
            end
            OP_MTHI: we_hi_s = 1'b1;
            OP_MTLO: we_lo_s = 1'b1;
            default: state_nxt_s = S_IDLE;
          endcase
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_MULT_RUN: begin
        if (mult_done) begin
          we_hi_s     = 1'b1;
          we_lo_s     = 1'b1;
          hi_d_s      = mult_hi;
          lo_d_s      = mult_lo;
          state_nxt_s = S_IDLE;
        end else if (timeout_fire_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_MULT_RUN;
        end
      end
      S_DIV_RUN: begin
        if (div_done) begin
          we_hi_s     = 1'b1;
          we_lo_s     = 1'b1;
          hi_d_s      = div_rem;
          lo_d_s      = div_quo;
          state_nxt_s = S_IDLE;
        end else if (timeout_fire_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DIV_RUN;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Run-cycle counter: zeroed on issue, counts every cycle spent in a run state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (issue_mult_s || issue_div_s) begin
      cnt_r <= {CW{1'b0}};
    end else if (state_r != S_IDLE) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Operand capture: only an accepted MULT/DIV updates the operands
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_a_r <= {W{1'b0}};
      op_b_r <= {W{1'b0}};
    end else if (issue_mult_s || issue_div_s) begin
      op_a_r <= rs_val;
      op_b_r <= rt_val;
    end else begin
      op_a_r <= op_a_r;
      op_b_r <= op_b_r;
    end
  end

  // Start and exception pulses: high only in the cycle after the issuing edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mult_start_r   <= 1'b0;
      div_start_r    <= 1'b0;
      div_zero_exc_r <= 1'b0;
    end else begin
      mult_start_r   <= issue_mult_s;
      div_start_r    <= issue_div_s;
      div_zero_exc_r <= div_zero_s;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timeout_err_r <= 1'b0;
    end else if (timeout_fire_s) begin
      timeout_err_r <= 1'b1;
    end else begin
      timeout_err_r <= timeout_err_r;
    end
  end

  hilo_regs #(.W(W)) u_hilo (
    .clock (clock),
    .reset (reset),
    .we_hi (we_hi_s),
    .we_lo (we_lo_s),
    .hi_d  (hi_d_s),
    .lo_d  (lo_d_s),
    .hi    (hi_q_s),
    .lo    (lo_q_s)
  );

  // Any non-NOP op must wait while a run is in flight, including the done cycle,
  // so MFHI/MFLO always observe the committed HI/LO.
  assign stall = op_valid && (op_s != OP_NOP) && (state_r != S_IDLE);

  // HI/LO read path, combinational from the registered HI/LO
  always_comb begin
    result       = {W{1'b0}};
    result_valid = 1'b0;
    if (idle_req_s && is_hilo_read(op_s)) begin
      result_valid = 1'b1;
      if (op_s == OP_MFHI) begin
        result = hi_q_s;
      end else begin
        result = lo_q_s;
      end
    end else begin
      result       = {W{1'b0}};
      result_valid = 1'b0;
    end
  end

  assign mult_start   = mult_start_r;
  assign div_start    = div_start_r;
  assign op_a         = op_a_r;
  assign op_b         = op_b_r;
  assign hi           = hi_q_s;
  assign lo           = lo_q_s;
  assign busy         = (state_r != S_IDLE);
  assign div_zero_exc = div_zero_exc_r;
  assign timeout_err  = timeout_err_r;

endmodule
